// File: rtl/dn_pkg.sv
// Shared definitions for the dn_benes distribution network and its sequencer.
// Covers the switch-level count, the route-signal width and the sequencer FSM states.
package dn_pkg;

    function automatic int n_levels_f(input int n);
        return 2 * $clog2(n) - 1;
    endfunction

    localparam int DN_N        = 8;
    localparam int DN_N_LEVELS = n_levels_f(DN_N);
    localparam int DN_RS_W     = DN_N_LEVELS * DN_N;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUTE = 2'd2,
        ST_DRAIN = 2'd3
    } dn_state_e;

endpackage

// File: rtl/dn_benes_ctrl_valid_pipe.sv
// NET_LAT-deep strobe delay line with synchronous clear.
// o_pending flags strobes that are still travelling and have not reached the output stage.
module valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_din,
    output logic o_dout,
    output logic o_pending
);

    logic [DEPTH-1:0] r_stages;

    generate
        if (DEPTH == 1) begin : g_one
            // single-stage delay
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_stages[0] <= 1'b0;
                end else begin
                    r_stages[0] <= i_din;
                end
            end
            assign o_pending = 1'b0;
        end else begin : g_multi
            // multi-stage shift toward the MSB
            always_ff @(posedge i_clk) begin
                if (i_clr) begin
                    r_stages <= '0;
                end else begin
                    r_stages <= {r_stages[DEPTH-2:0], i_din};
                end
            end
            assign o_pending = |r_stages[DEPTH-2:0];
        end
    endgenerate

    assign o_dout = r_stages[DEPTH-1];

endmodule

// File: rtl/dn_benes_ctrl.sv
// Job sequencer for the dn_benes network: a config table, a route-signal shadow register,
// and an IDLE/LOAD/ROUTE/DRAIN FSM driving set_en, route_en and the registered input vector.
module dn_benes_ctrl
    import dn_pkg::*;
#(
    parameter int DW_DATA   = 8,
    parameter int N         = DN_N,
    parameter int N_LEVELS  = n_levels_f(N),
    parameter int CFG_DEPTH = 4,
    parameter int LEN_W     = 8,
    parameter int NET_LAT   = 1,
    localparam int CW       = $clog2(CFG_DEPTH),
    localparam int RS_W     = N_LEVELS * N,
    localparam int VW       = DW_DATA * N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_wr_en,
    input  logic [CW-1:0]     cfg_wr_addr,
    input  logic [RS_W-1:0]   cfg_wr_data,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [CW-1:0]     job_cfg_id,
    input  logic [LEN_W-1:0]  job_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VW-1:0]     in_data,
    output logic              bn_set_en,
    output logic              bn_route_en,
    output logic [RS_W-1:0]   bn_route_signals,
    output logic [VW-1:0]     bn_in,
    input  logic [VW-1:0]     bn_out,
    output logic              out_valid,
    output logic [VW-1:0]     out_data,
    output logic              job_done,
    output logic              busy
);

    dn_state_e         r_state;
    dn_state_e         w_next_state;
    logic [RS_W-1:0]   r_cfg_table [CFG_DEPTH];
    logic [RS_W-1:0]   r_route_signals;
    logic [RS_W-1:0]   w_cfg_sel;
    logic [VW-1:0]     r_bn_in;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  w_count_inc;
    logic              r_job_ready;
    logic              r_in_ready;
    logic              r_set_en;
    logic              r_route_en;
    logic              r_job_done;
    logic              r_busy;
    logic              w_accept;
    logic              w_accept_run;
    logic              w_zero_done;
    logic              w_hs;
    logic              w_done;
    logic              w_pipe_pending;
    logic              w_out_valid;

    // Table entry for the incoming job; a same-cycle write to that entry takes precedence.
    always_comb begin
        if (cfg_wr_en && (cfg_wr_addr == job_cfg_id)) begin
            w_cfg_sel = cfg_wr_data;
        end else begin
            w_cfg_sel = r_cfg_table[job_cfg_id];
        end
    end

    // Next-state and per-cycle event decode.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_accept_run = 1'b0;
        w_zero_done  = 1'b0;
        w_hs         = 1'b0;
        w_done       = 1'b0;
        w_count_inc  = r_count + {{(LEN_W-1){1'b0}}, 1'b1};
        case (r_state)
            ST_IDLE: begin
                w_accept = job_valid && r_job_ready;
                if (w_accept && (job_len != {LEN_W{1'b0}})) begin
                    w_accept_run = 1'b1;
                    w_next_state = ST_LOAD;
                end else begin
                    w_zero_done  = w_accept;
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                w_next_state = ST_ROUTE;
            end
            ST_ROUTE: begin
                w_hs = in_valid && r_in_ready;
                if (w_hs && (w_count_inc == r_len)) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_ROUTE;
                end
            end
            ST_DRAIN: begin
                // Anything still upstream of the output stage keeps us here.
                if (!r_route_en && !w_pipe_pending) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM state, registered control outputs, shadow, count and input register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_job_ready     <= 1'b0;
            r_in_ready      <= 1'b0;
            r_set_en        <= 1'b0;
            r_route_en      <= 1'b0;
            r_job_done      <= 1'b0;
            r_busy          <= 1'b0;
            r_len           <= '0;
            r_count         <= '0;
            r_route_signals <= '0;
            r_bn_in         <= '0;
        end else begin
            r_state     <= w_next_state;
            // ready stays low in the job_done cycle so jobs never overlap
            r_job_ready <= (w_next_state == ST_IDLE) && !w_done;
            r_in_ready  <= (w_next_state == ST_ROUTE);
            r_set_en    <= (w_next_state == ST_LOAD);
            r_busy      <= (w_next_state != ST_IDLE);
            r_route_en  <= w_hs;
            r_job_done  <= w_done || w_zero_done;
            if (w_accept_run) begin
                r_len           <= job_len;
                r_count         <= '0;
                r_route_signals <= w_cfg_sel;
            end
            if (w_hs) begin
                r_bn_in <= in_data;
                r_count <= w_count_inc;
            end
        end
    end

    // Config table storage; writes are legal in every state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CFG_DEPTH; i++) begin
                r_cfg_table[i] <= '0;
            end
        end else if (cfg_wr_en) begin
            r_cfg_table[cfg_wr_addr] <= cfg_wr_data;
        end
    end

    valid_pipe #(
        .DEPTH (NET_LAT)
    ) u_valid_pipe (
        .i_clk     (clk),
        .i_clr     (reset),
        .i_din     (r_route_en),
        .o_dout    (w_out_valid),
        .o_pending (w_pipe_pending)
    );

    assign job_ready        = r_job_ready;
    assign in_ready         = r_in_ready;
    assign bn_set_en        = r_set_en;
    assign bn_route_en      = r_route_en;
    assign bn_route_signals = r_route_signals;
    assign bn_in            = r_bn_in;
    assign out_valid        = w_out_valid;
    assign out_data         = bn_out;
    assign job_done         = r_job_done;
    assign busy             = r_busy;

endmodule

// File: tb/tb_dn_benes_ctrl.sv
// Bench for dn_benes_ctrl with a one-cycle stand-in network that rotates the vector by one byte.
// Expected outputs are queued at each input handshake and popped when out_valid is seen.
module tb_dn_benes_ctrl;

    localparam int DW = 8, NP = 8, NL = 5, CD = 4, LW = 8, NLAT = 1;
    localparam int RSW = NL * NP, VW = DW * NP, CW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            cfg_wr_en;
    logic [CW-1:0]   cfg_wr_addr;
    logic [RSW-1:0]  cfg_wr_data;
    logic            job_valid;
    logic            job_ready;
    logic [CW-1:0]   job_cfg_id;
    logic [LW-1:0]   job_len;
    logic            in_valid;
    logic            in_ready;
    logic [VW-1:0]   in_data;
    logic            bn_set_en;
    logic            bn_route_en;
    logic [RSW-1:0]  bn_route_signals;
    logic [VW-1:0]   bn_in;
    logic [VW-1:0]   bn_out = '0;
    logic            out_valid;
    logic [VW-1:0]   out_data;
    logic            job_done;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int cnt_out = 0, cnt_route = 0, cnt_set = 0, cnt_done = 0;
    int last_out_cyc = -10;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp_v;

    always #5 clk = ~clk;

    dn_benes_ctrl #(
        .DW_DATA(DW), .N(NP), .N_LEVELS(NL), .CFG_DEPTH(CD), .LEN_W(LW), .NET_LAT(NLAT)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .job_valid(job_valid), .job_ready(job_ready), .job_cfg_id(job_cfg_id), .job_len(job_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .bn_set_en(bn_set_en), .bn_route_en(bn_route_en), .bn_route_signals(bn_route_signals),
        .bn_in(bn_in), .bn_out(bn_out),
        .out_valid(out_valid), .out_data(out_data), .job_done(job_done), .busy(busy)
    );

    function automatic logic [VW-1:0] mk(input int k);
        logic [VW-1:0] v;
        for (int j = 0; j < NP; j++) v[8*j +: 8] = 8'((8 * k + j) % 256);
        return v;
    endfunction

    function automatic logic [VW-1:0] rot(input logic [VW-1:0] v);
        return {v[VW-9:0], v[VW-1:VW-8]};
    endfunction

    // stand-in network with NET_LAT = 1
    always @(posedge clk) begin
        if (bn_route_en) bn_out <= rot(bn_in);
    end

    always @(posedge clk) cyc++;

    // output monitor and scoreboard
    always @(negedge clk) begin
        if (out_valid) begin
            cnt_out++;
            last_out_cyc = cyc;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: out_valid with out_data=%h, no vector outstanding", out_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (out_data !== exp_v) begin
                    n_err++;
                    $display("FAIL sb_data: got %h expected %h", out_data, exp_v);
                end
            end
        end
        if (bn_route_en) cnt_route++;
        if (bn_set_en) cnt_set++;
        if (job_done) cnt_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        cnt_out = 0; cnt_route = 0; cnt_set = 0; cnt_done = 0;
    endtask

    task automatic write_cfg(input logic [CW-1:0] a, input logic [RSW-1:0] d);
        cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
        tick();
        cfg_wr_en = 1'b0;
    endtask

    // returns in the cycle after acceptance
    task automatic start_job(input logic [CW-1:0] id, input logic [LW-1:0] len);
        int b = 0;
        job_valid = 1'b1; job_cfg_id = id; job_len = len;
        while (!job_ready && b < 50) begin
            tick();
            b++;
        end
        n_vec++;
        if (!job_ready) begin
            n_err++;
            $display("FAIL job_accept: job_ready=%b after %0d cycles, required 1", job_ready, b);
        end
        tick();
        job_valid = 1'b0;
    endtask

    task automatic send_vecs(input int n, input int base, input bit bubble);
        int k = 0;
        int b = 0;
        bit ph = 1'b1;
        while (k < n && b < 4000) begin
            in_valid = bubble ? ph : 1'b1;
            ph = ~ph;
            in_data = mk(base + k);
            if (in_valid && in_ready) begin
                exp_q.push_back(rot(mk(base + k)));
                k++;
            end
            tick();
            b++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (k != n) begin
            n_err++;
            $display("FAIL send_vecs: %0d handshakes, required %0d", k, n);
        end
    endtask

    task automatic wait_done(input int n);
        int b = 0;
        while (!job_done && b < 300) begin
            tick();
            b++;
        end
        n_vec++;
        if (!job_done) begin
            n_err++;
            $display("FAIL done_timeout: job_done=%b, required 1", job_done);
        end else begin
            n_vec++;
            if (last_out_cyc != cyc - 1 || job_ready !== 1'b0) begin
                n_err++;
                $display("FAIL done_timing: last out_valid cyc %0d, done cyc %0d, job_ready=%b; required done one cycle after, ready 0",
                         last_out_cyc, cyc, job_ready);
            end
            n_vec++;
            if (cnt_out != n || exp_q.size() != 0) begin
                n_err++;
                $display("FAIL out_count: %0d outputs, %0d pending, required %0d and 0", cnt_out, exp_q.size(), n);
            end
            tick();
            n_vec++;
            if (job_ready !== 1'b1 || job_done !== 1'b0 || cnt_done != 1) begin
                n_err++;
                $display("FAIL after_done: job_ready=%b job_done=%b dones=%0d, required 1 0 1", job_ready, job_done, cnt_done);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_vec++;
        if ({job_ready, in_ready, bn_set_en, bn_route_en, out_valid, job_done, busy} !== 7'd0 ||
            bn_route_signals !== '0 || bn_in !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: ctrl=%b rs=%h bn_in=%h, required all 0",
                     {job_ready, in_ready, bn_set_en, bn_route_en, out_valid, job_done, busy}, bn_route_signals, bn_in);
        end
        reset = 1'b0;
        tick();
        n_vec++;
        if (job_ready !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: job_ready=%b busy=%b, required 1 0", job_ready, busy);
        end
    endtask

    task automatic test_single();
        write_cfg(2'd1, 40'h5A3A586406);
        clr_counts();
        start_job(2'd1, 8'd3);
        n_vec++;
        if (bn_set_en !== 1'b1 || bn_route_signals !== 40'h5A3A586406 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_load: set_en=%b rs=%h in_ready=%b busy=%b, required 1 5a3a586406 0 1",
                     bn_set_en, bn_route_signals, in_ready, busy);
        end
        tick();
        n_vec++;
        if (bn_set_en !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_route_start: set_en=%b in_ready=%b, required 0 1", bn_set_en, in_ready);
        end
        send_vecs(3, 0, 1'b0);
        wait_done(3);
        n_vec++;
        if (cnt_route != 3 || cnt_set != 1) begin
            n_err++;
            $display("FAIL single_counts: route_en=%0d set_en=%0d, required 3 1", cnt_route, cnt_set);
        end
    endtask

    task automatic test_bubbles();
        clr_counts();
        start_job(2'd1, 8'd4);
        send_vecs(4, 10, 1'b1);
        wait_done(4);
        n_vec++;
        if (cnt_route != 4) begin
            n_err++;
            $display("FAIL bubble_route_en: %0d route_en cycles, required 4", cnt_route);
        end
    endtask

    task automatic test_bypass();
        write_cfg(2'd2, 40'h1111111111);
        clr_counts();
        cfg_wr_en = 1'b1; cfg_wr_addr = 2'd2; cfg_wr_data = 40'hA1B2C3D4E5;
        start_job(2'd2, 8'd2);
        cfg_wr_en = 1'b0;
        n_vec++;
        if (bn_set_en !== 1'b1 || bn_route_signals !== 40'hA1B2C3D4E5) begin
            n_err++;
            $display("FAIL bypass_load: set_en=%b rs=%h, required 1 a1b2c3d4e5", bn_set_en, bn_route_signals);
        end
        tick();
        write_cfg(2'd2, 40'h0F0E0D0C0B);
        send_vecs(2, 40, 1'b0);
        n_vec++;
        if (bn_route_signals !== 40'hA1B2C3D4E5) begin
            n_err++;
            $display("FAIL isolation: rs=%h, required a1b2c3d4e5", bn_route_signals);
        end
        wait_done(2);
        clr_counts();
        start_job(2'd2, 8'd1);
        n_vec++;
        if (bn_route_signals !== 40'h0F0E0D0C0B) begin
            n_err++;
            $display("FAIL table_update: rs=%h, required 0f0e0d0c0b", bn_route_signals);
        end
        send_vecs(1, 60, 1'b0);
        wait_done(1);
    endtask

    task automatic test_zero_len();
        clr_counts();
        start_job(2'd1, 8'd0);
        n_vec++;
        if (job_done !== 1'b1 || bn_set_en !== 1'b0 || busy !== 1'b0 || job_ready !== 1'b1) begin
            n_err++;
            $display("FAIL zero_len_done: done=%b set_en=%b busy=%b ready=%b, required 1 0 0 1",
                     job_done, bn_set_en, busy, job_ready);
        end
        tick();
        n_vec++;
        if (job_done !== 1'b0 || cnt_set != 0 || cnt_done != 1 || cnt_route != 0) begin
            n_err++;
            $display("FAIL zero_len_after: done=%b sets=%0d dones=%0d routes=%0d, required 0 0 1 0",
                     job_done, cnt_set, cnt_done, cnt_route);
        end
    endtask

    task automatic test_max_len();
        clr_counts();
        start_job(2'd3, 8'd255);
        send_vecs(255, 100, 1'b0);
        wait_done(255);
        n_vec++;
        if (cnt_route != 255) begin
            n_err++;
            $display("FAIL max_len_routes: %0d route_en cycles, required 255", cnt_route);
        end
    endtask

    task automatic test_reset_mid();
        clr_counts();
        start_job(2'd1, 8'd5);
        send_vecs(2, 200, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        clr_counts();
        n_vec++;
        if (bn_route_signals !== '0 || bn_in !== '0) begin
            n_err++;
            $display("FAIL mid_reset_clear: rs=%h bn_in=%h, required 0 0", bn_route_signals, bn_in);
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || job_done !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_quiet: cycle %0d out_valid=%b busy=%b done=%b, required 0 0 0",
                         i, out_valid, busy, job_done);
            end
            tick();
        end
        n_vec++;
        if (cnt_out != 0 || cnt_done != 0) begin
            n_err++;
            $display("FAIL mid_reset_drop: outputs=%0d dones=%0d, required 0 0", cnt_out, cnt_done);
        end
        start_job(2'd1, 8'd2);
        n_vec++;
        if (bn_route_signals !== '0 || bn_set_en !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_table: rs=%h set_en=%b, required 0 1", bn_route_signals, bn_set_en);
        end
        send_vecs(2, 220, 1'b0);
        wait_done(2);
    endtask

    initial begin
        reset = 1'b1;
        cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        job_valid = 1'b0; job_cfg_id = '0; job_len = '0;
        in_valid = 1'b0; in_data = '0;
        test_reset();
        test_single();
        test_bubbles();
        test_bypass();
        test_zero_len();
        test_max_len();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
